// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - 4-digit multiplexed common-anode seven-segment scanner for BCD digits
//
// Purpose: scans four BCD digits onto a multiplexed common-anode display, one
// digit per prescaled slot. At each frame start all digits and decimal points
// are snapshotted, so the display never tears mid-frame.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the leading zero
// digits (digit3 down to digit1). Digit0 is never blanked. Without the macro,
// every digit is decoded.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_clr     synchronous active-high reset, overrides all other inputs
//   i_en      scan enable; 0 freezes the prescaler, digit select and outputs
//   i_digits  [3:0]=digit0 (LSD) .. [15:12]=digit3 (MSD)
//   i_dp_in   per-digit decimal point, 1=lit
//   o_seg     active-low segments {g,f,e,d,c,b,a}
//   o_dp      active-low decimal point
//   o_an      active-low anode select, o_an[i] enables digit i
//   o_frame   one-cycle pulse when digit0 of a new frame is first shown
module bcd_seg_scanner #(
  parameter int DIV_W = 16,
  parameter int DIV   = 4
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp_in,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [3:0]  o_an,
  output logic        o_frame
);

  localparam logic [DIV_W-1:0] L_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic [15:0]      r_shadow;
  logic [3:0]       r_shadow_dp;
  logic             r_blank;

  logic        w_tick;
  logic        w_frame_start;
  logic [1:0]  w_sel_nxt;
  logic [15:0] w_shadow_nxt;
  logic [3:0]  w_shadow_dp_nxt;
  logic        w_blank_nxt;
  logic [3:0]  w_digit;
  logic [3:0]  w_lzb;
  logic [6:0]  w_seg_nxt;
  logic [3:0]  w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;  // non-BCD shows a dash
    endcase
    return s;
  endfunction

  // Outputs are registered from the next-state values, so they change on the
  // same edge as the digit select and never see the inputs combinationally.
  always_comb begin
    w_tick          = i_en && (r_cnt == L_LAST);
    w_frame_start   = w_tick && (r_sel == 2'd3);
    w_sel_nxt       = r_sel + 2'd1;
    w_shadow_nxt    = w_frame_start ? i_digits : r_shadow;
    w_shadow_dp_nxt = w_frame_start ? i_dp_in : r_shadow_dp;
    // Blanking only ever clears at a frame start; reset is the only way back.
    w_blank_nxt     = r_blank && !w_frame_start;

    w_digit = 4'h0;
    case (w_sel_nxt)
      2'd0: w_digit = w_shadow_nxt[3:0];
      2'd1: w_digit = w_shadow_nxt[7:4];
      2'd2: w_digit = w_shadow_nxt[11:8];
      2'd3: w_digit = w_shadow_nxt[15:12];
      default: w_digit = 4'h0;
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank only if it and every more-significant digit are zero.
    w_lzb[3] = (w_shadow_nxt[15:12] == 4'd0);
    w_lzb[2] = w_lzb[3] && (w_shadow_nxt[11:8] == 4'd0);
    w_lzb[1] = w_lzb[2] && (w_shadow_nxt[7:4] == 4'd0);
    w_lzb[0] = 1'b0;
`else
    w_lzb = 4'b0000;
`endif

    w_seg_nxt = w_lzb[w_sel_nxt] ? 7'b1111111 : f_decode(w_digit);
    w_an_nxt  = ~(4'b0001 << w_sel_nxt);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt       <= '0;
      r_sel       <= 2'd3;
      r_shadow    <= 16'h0;
      r_shadow_dp <= 4'h0;
      r_blank     <= 1'b1;
      o_an        <= 4'b1111;
      o_seg       <= 7'b1111111;
      o_dp        <= 1'b1;
      o_frame     <= 1'b0;
    end else begin
      // The frame marker is a single-cycle pulse; it drops on the next edge
      // whether or not the scan is enabled.
      o_frame <= w_frame_start;
      if (i_en) begin
        if (w_tick) begin
          r_cnt       <= '0;
          r_sel       <= w_sel_nxt;
          r_shadow    <= w_shadow_nxt;
          r_shadow_dp <= w_shadow_dp_nxt;
          r_blank     <= w_blank_nxt;
          if (w_blank_nxt) begin
            o_an  <= 4'b1111;
            o_seg <= 7'b1111111;
            o_dp  <= 1'b1;
          end else begin
            o_an  <= w_an_nxt;
            o_seg <= w_seg_nxt;
            o_dp  <= ~w_shadow_dp_nxt[w_sel_nxt];
          end
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - scoreboard bench for bcd_seg_scanner
module tb_bcd_seg_scanner;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  bcd_seg_scanner #(.DIV_W(16), .DIV(DIV)) dut (
    .i_clk    (clk),
    .i_clr    (clr),
    .i_en     (en),
    .i_digits (digits),
    .i_dp_in  (dp_in),
    .o_seg    (seg),
    .o_dp     (dp),
    .o_an     (an),
    .o_frame  (frame)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [6:0] dec_tab [16];

  // Reference model: count of enabled cycles since reset, the captured frame
  // snapshot and whether the last edge started a frame.
  int          m_cnt;
  logic [15:0] m_snap;
  logic [3:0]  m_snap_dp;
  logic        m_frame;

  function automatic exp_t model_out();
    exp_t r;
    int ticks;
    int sel;
    logic [15:0] upper;
    logic [3:0]  dig;
    ticks = m_cnt / DIV;
    r.frame = m_frame;
    if (ticks == 0) begin
      r.an  = 4'b1111;
      r.seg = 7'b1111111;
      r.dp  = 1'b1;
    end else begin
      sel   = (ticks + 3) % 4;
      r.an  = ~(4'b0001 << sel);
      upper = m_snap >> (4 * sel);
      dig   = upper[3:0];
      r.seg = dec_tab[dig];
`ifdef LEADING_ZERO_BLANK_EN
      if (sel != 0 && upper == 16'h0) r.seg = 7'b1111111;
`endif
      r.dp  = ~m_snap_dp[sel];
    end
    return r;
  endfunction

  task automatic step(input logic c, input logic e, input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    #1;
    clr = c; en = e; digits = d; dp_in = p;
    if (c) begin
      m_cnt = 0; m_snap = 16'h0; m_snap_dp = 4'h0; m_frame = 1'b0;
    end else if (e) begin
      m_cnt++;
      m_frame = 1'b0;
      if ((m_cnt % DIV) == 0 && ((m_cnt / DIV) % 4) == 1) begin
        m_snap = d; m_snap_dp = p; m_frame = 1'b1;
      end
    end else begin
      m_frame = 1'b0;
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input logic e, input logic [15:0] d, input logic [3:0] p);
    for (int i = 0; i < n; i++) step(1'b0, e, d, p);
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got=%b want=%b", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("an",    {3'b000, an},    {3'b000, x.an});
        chk("seg",   seg,             x.seg);
        chk("dp",    {6'b0, dp},      {6'b0, x.dp});
        chk("frame", {6'b0, frame},   {6'b0, x.frame});
      end
    end
  end

  initial begin : stim
    logic [15:0] rd;
    logic        rc;
    logic        re;
    dec_tab[0] = 7'b1000000; dec_tab[1] = 7'b1111001; dec_tab[2] = 7'b0100100;
    dec_tab[3] = 7'b0110000; dec_tab[4] = 7'b0011001; dec_tab[5] = 7'b0010010;
    dec_tab[6] = 7'b0000010; dec_tab[7] = 7'b1111000; dec_tab[8] = 7'b0000000;
    dec_tab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b0111111;
    m_cnt = 0; m_snap = 16'h0; m_snap_dp = 4'h0; m_frame = 1'b0;
    clr = 1'b1; en = 1'b0; digits = 16'h0; dp_in = 4'h0;

    step(1'b1, 1'b1, 16'hFFFF, 4'hF);
    step(1'b1, 1'b0, 16'h1234, 4'h0);
    run(24, 1'b1, 16'h1234, 4'h0);        // ends inside the digit1 slot
    run(5, 1'b1, 16'h5678, 4'h0);         // mid-frame change, now inside digit2 slot
    run(10, 1'b0, 16'h5678, 4'h0);        // frozen scan
    run(12, 1'b1, 16'h5678, 4'h0);
    run(20, 1'b1, 16'h00A9, 4'b0010);     // dash on digit1, DP lit there
    run(3, 1'b1, 16'h00A9, 4'b0010);
    step(1'b1, 1'b1, 16'h00A9, 4'b0010);  // reset mid-frame
    run(20, 1'b1, 16'h0045, 4'h0);
    run(20, 1'b1, 16'h0000, 4'h1);
    run(20, 1'b1, 16'h0405, 4'h4);
    step(1'b0, 1'b1, 16'hA0B0, 4'h8);
    run(3, 1'b1, 16'hA0B0, 4'h8);         // DIV=4 boundary, EN then freeze
    run(2, 1'b0, 16'h0001, 4'h0);

    rd = 16'h9876;
    for (int i = 0; i < 400; i++) begin
      rc = ($urandom_range(0, 99) == 0);
      re = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) rd = 16'($urandom);
      step(rc, re, rd, 4'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
